// File: rtl/io_ring_pkg.sv
// io_ring_pkg: shared types and limits for the pad-ring channel bank.
//   edge_mode_e  - per-channel edge detector selection
//   IO_SYNC_MIN/IO_SYNC_MAX - legal synchroniser depth range
package io_ring_pkg;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    RISE = 2'd1,
    FALL = 2'd2,
    BOTH = 2'd3
  } edge_mode_e;

  localparam int IO_SYNC_MIN = 2;
  localparam int IO_SYNC_MAX = 4;

endpackage

// File: rtl/io_sync.sv
// io_sync: single-bit multi-flop synchroniser, resets to 0.
//   clk   - destination clock
//   rst_n - asynchronous active-low reset
//   d     - asynchronous input
//   q     - synchronised output (last stage)
module io_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] stage;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage <= '0;
    end else begin
      stage <= {stage[STAGES-2:0], d};
    end
  end

  assign q = stage[STAGES-1];

endmodule

// File: rtl/io_ring_bank.sv
// io_ring_bank: registered bank of bidirectional pad channels.
//   clk, rst_n  - core clock, asynchronous active-low reset
//   out_data    - per-channel value to drive
//   out_en      - per-channel drive enable (1 = drive)
//   edge_mode   - 2 bits per channel, see edge_mode_e
//   irq_clr     - write-1-to-clear for irq_status
//   pad_a       - to pad A pins (registered)
//   pad_oen     - to pad OEN pins, active low (registered)
//   pad_y       - from pad Y pins (asynchronous)
//   in_data     - synchronised pad values
//   irq_status  - sticky edge flags
//   irq         - OR of irq_status
module io_ring_bank
  import io_ring_pkg::*;
#(
  parameter int NCH         = 8,
  parameter int SYNC_STAGES = 2,
  parameter bit OEN_RESET   = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NCH-1:0]   out_data,
  input  logic [NCH-1:0]   out_en,
  input  logic [2*NCH-1:0] edge_mode,
  input  logic [NCH-1:0]   irq_clr,
  output logic [NCH-1:0]   pad_a,
  output logic [NCH-1:0]   pad_oen,
  input  logic [NCH-1:0]   pad_y,
  output logic [NCH-1:0]   in_data,
  output logic [NCH-1:0]   irq_status,
  output logic             irq
);

  if (NCH < 1 || NCH > 32) begin : g_bad_nch
    $error("io_ring_bank: NCH must be in 1..32");
  end
  if (SYNC_STAGES < IO_SYNC_MIN || SYNC_STAGES > IO_SYNC_MAX) begin : g_bad_sync
    $error("io_ring_bank: SYNC_STAGES out of range");
  end

  logic [NCH-1:0] prev_in;
  logic [NCH-1:0] edge_det;

  // Output path: registered so nothing combinational reaches the pads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pad_a   <= '0;
      pad_oen <= {NCH{OEN_RESET}};
    end else begin
      pad_a   <= out_data;
      pad_oen <= ~out_en;
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_sync
    io_sync #(.STAGES(SYNC_STAGES)) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (pad_y[i]),
      .q     (in_data[i])
    );
  end

  always_comb begin
    edge_det = '0;
    for (int i = 0; i < NCH; i++) begin
      case (edge_mode_e'(edge_mode[2*i +: 2]))
        RISE:    edge_det[i] = ~prev_in[i] &  in_data[i];
        FALL:    edge_det[i] =  prev_in[i] & ~in_data[i];
        BOTH:    edge_det[i] =  prev_in[i] ^  in_data[i];
        default: edge_det[i] = 1'b0;
      endcase
    end
  end

  // A new edge beats a clear arriving in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_in    <= '0;
      irq_status <= '0;
    end else begin
      prev_in    <= in_data;
      irq_status <= edge_det | (irq_status & ~irq_clr);
    end
  end

  assign irq = |irq_status;

endmodule

// File: doc/io_ring_bank.md
# io_ring_bank

Parametrised, registered bank of bidirectional pad channels that sits between core logic and a row of bidirectional tristate pad cells (A / OEN / Y pins). Each channel has a registered output value and a registered output enable driven to the pad. The pad's Y return is synchronised into the core clock domain. Configurable edge detection sets sticky per-channel interrupt status bits, which are OR-reduced into a single interrupt line.

## Interface
Parameters:
- NCH, 8, number of pad channels (1..32)
- SYNC_STAGES, 2, synchroniser depth on the pad input path (2..4)
- OEN_RESET, 1, reset value of every pad_oen bit (1 = pad tristated)

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  core clock; all state is rising-edge triggered
- rst_n  in  1  asynchronous active-low reset; deassertion is synchronous to clk upstream
- out_data  in  NCH  value to drive per channel
- out_en  in  NCH  1 = drive the pad, 0 = release it
- edge_mode  in  2*NCH  per-channel edge select: bits [2i+1:2i] for channel i
- irq_clr  in  NCH  write-1-to-clear for irq_status
- pad_a  out  NCH  to pad A pin
- pad_oen  out  NCH  to pad OEN pin (active-low enable)
- pad_y  in  NCH  from pad Y pin (asynchronous)
- in_data  out  NCH  synchronised pad value
- irq_status  out  NCH  sticky edge-detect flags
- irq  out  1  OR of irq_status

## Operation
- Output path: pad_a <= out_data; pad_oen <= ~out_en. Both are registered with no combinational path from core to pad.
- Input path: each pad_y bit goes through SYNC_STAGES flops. in_data is the last stage. prev_in is one further flop.
- Edge detect, per channel i, with en = edge_mode[2i+1:2i]:
  - NONE (0): no edge is detected.
  - RISE (1): edge when prev_in=0 and in_data=1.
  - FALL (2): edge when prev_in=1 and in_data=0.
  - BOTH (3): edge on either transition.
- irq_status[i] next value = edge_i | (irq_status[i] & ~irq_clr[i]). When an edge and irq_clr arrive in the same cycle, set wins.
- Changing edge_mode does not clear irq_status. A mode change takes effect on the next clock.
- Loopback is inherent: while out_en[i]=1, in_data[i] follows the driven value after the pad delay plus synchroniser latency.

## Timing
- Reset values:
  - pad_oen = {NCH{OEN_RESET}}
  - pad_a = 0
  - in_data = 0
  - prev_in = 0
  - all synchroniser stages = 0
  - irq_status = 0
  - irq = 0
- Reset asserted mid-operation: all flops take reset values immediately (asynchronous). Pads release within the pad's tplz/tphz.
- out_data/out_en to pad_a/pad_oen: 1 cycle.
- pad_y to in_data: SYNC_STAGES cycles, ±1 cycle sampling uncertainty.
- in_data transition to irq_status set: 1 cycle after in_data changes. irq is registered-equivalent, i.e. combinational OR of registered status, with no extra cycle.
- irq_clr to irq_status low: 1 cycle, unless an edge arrives in the same cycle.
- Pulses on pad_y shorter than one clk period may be missed. This is not an error condition.
- After reset deassertion, the first in_data change from 0 to the real pad level (after SYNC_STAGES cycles) is detected as an edge if the mode matches. Software clears it.

## Structure
- Package io_ring_pkg holds:
  - typedef edge_mode_e (NONE=2'd0, RISE=2'd1, FALL=2'd2, BOTH=2'd3)
  - localparams IO_SYNC_MIN=2 and IO_SYNC_MAX=4
- Sub-module io_sync: parametrised-depth single-bit synchroniser with async active-low reset to 0. It is instantiated NCH times in a generate loop.
- Parameter range checks are elaboration-time assertions.

## Test plan
- Reset with NCH=8, OEN_RESET=1: pad_oen=8'hFF, pad_a=0, in_data=0, irq=0. Then set out_en=8'h0F and out_data=8'h05: one cycle later pad_oen=8'hF0 and pad_a=8'h05.
- Channel 3 in RISE mode: pad_y[3] 0→1 → in_data[3]=1 after 2 cycles, irq_status[3]=1 one cycle later, irq=1. Then pad_y[3] 1→0 → no new set.
- Channel 0 in BOTH mode: toggle pad_y[0] every 4 cycles ×3 → three set events. A single irq_clr[0] pulse between toggles clears the flag, and the next toggle sets it again.
- Simultaneous: irq_clr[5]=1 in the same cycle a FALL edge is detected on channel 5 → irq_status[5] stays 1.
- Reset mid-operation: assert rst_n=0 asynchronously while pad_oen=0 and irq_status=8'hA5 → all outputs return to reset values without a clock edge.
- Loopback with SYNC_STAGES=3: out_en[7]=1, out_data[7] toggles → in_data[7] follows 4 cycles after the out_data change (1 output + 3 sync).
